// File: rtl/segment_display_capture_pkg.sv
// Shared definitions for the seven-segment capture monitor: segment bit order,
// the active-low hex glyph table and the capture FSM encoding.
package segment_pkg;

  localparam int SEG_TOP       = 0;
  localparam int SEG_RIGHT_TOP = 1;
  localparam int SEG_RIGHT_BOT = 2;
  localparam int SEG_BOTTOM    = 3;
  localparam int SEG_LEFT_BOT  = 4;
  localparam int SEG_LEFT_TOP  = 5;
  localparam int SEG_MIDDLE    = 6;
  localparam int SEG_WIDTH     = SEG_MIDDLE + 1;

  // Active-low glyphs, written MSB (middle) first, indexed by the nibble shown.
  localparam logic [SEG_WIDTH-1:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETTLING  = 2'd1,
    ST_COMMITTED = 2'd2
  } capture_state_e;

endpackage

// File: rtl/segment_display_capture_encoder.sv
// Combinational reverse lookup of an active-low segment pattern into its hex nibble,
// with flags for a table hit and for the all-off blank pattern.
module seven_segment_encoder
  import segment_pkg::*;
(
  input  logic [SEG_WIDTH-1:0] seg_pattern,
  output logic                 match,
  output logic                 is_blank,
  output logic [3:0]           nibble
);

  always_comb begin
    match    = 1'b0;
    nibble   = 4'd0;
    is_blank = (seg_pattern == SEG_BLANK);
    for (int n = 0; n < 16; n++) begin
      if (!match && (seg_pattern == SEG_TABLE[n])) begin
        match  = 1'b1;
        nibble = 4'(n);
      end
    end
  end

endmodule

// File: rtl/segment_display_capture.sv
// Watches the multiplexed active-low display bus and recovers the hex value per digit
// once a pattern has been stable for STABLE_CYCLES samples.
//
// state        | meaning
// ST_IDLE      | no anode low, or several low; counter held at 0, no commit
// ST_SETTLING  | exactly one anode low, dwell not yet reached
// ST_COMMITTED | dwell reached and committed; waits for the sample to change
module segment_display_capture
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEG_WIDTH-1:0]    segBits,
  input  logic [NUM_DIGITS-1:0]   anodeBits,
  input  logic                    clearError,
  output logic [4*NUM_DIGITS-1:0] digitBits,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic                    errorFlag,
  output logic                    frameDone
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [SEG_WIDTH-1:0]    last_seg_q, last_seg_d;
  logic [NUM_DIGITS-1:0]   last_anode_q, last_anode_d;
  logic [7:0]              stable_count_q, stable_count_d;
  capture_state_e          state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digit_bits_q, digit_bits_d;
  logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic [NUM_DIGITS-1:0]   seen_mask_q, seen_mask_d;
  logic                    error_flag_q, error_flag_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0] sel, last_sel, commit_mask, seen_next;
  logic                  any_low, one_low, multi_low, last_multi, same, commit, err_set;
  logic                  enc_match, enc_blank;
  logic [3:0]            enc_nibble;

  seven_segment_encoder u_encoder (
    .seg_pattern (segBits),
    .match       (enc_match),
    .is_blank    (enc_blank),
    .nibble      (enc_nibble)
  );

  always_comb begin
    sel        = ~anodeBits;
    last_sel   = ~last_anode_q;
    any_low    = |sel;
    one_low    = any_low && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    multi_low  = any_low && !one_low;
    last_multi = (last_sel & (last_sel - NUM_DIGITS'(1))) != '0;
    same       = (segBits == last_seg_q) && (anodeBits == last_anode_q);

    last_seg_d   = segBits;
    last_anode_d = anodeBits;

    if (!one_low || !same) begin
      stable_count_d = 8'd0;
    end else if (stable_count_q < STABLE_MAX) begin
      stable_count_d = stable_count_q + 8'd1;
    end else begin
      stable_count_d = stable_count_q;
    end

    if (!one_low) begin
      state_d = ST_IDLE;
    end else if (stable_count_d == STABLE_MAX) begin
      state_d = ST_COMMITTED;
    end else begin
      state_d = ST_SETTLING;
    end

    // Only the entry into COMMITTED commits, so a held pattern never re-commits.
    commit      = (state_d == ST_COMMITTED) && (state_q != ST_COMMITTED);
    commit_mask = commit ? sel : '0;

    digit_bits_d  = digit_bits_q;
    digit_valid_d = digit_valid_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit_mask[i]) begin
        if (enc_match) begin
          digit_bits_d[4*i +: 4] = enc_nibble;
          digit_valid_d[i]       = 1'b1;
        end else begin
          digit_valid_d[i] = 1'b0;
        end
      end
    end

    err_set = (multi_low && !last_multi) || (commit && !enc_match && !enc_blank);
    if (err_set) begin
      error_flag_d = 1'b1;
    end else if (clearError) begin
      error_flag_d = 1'b0;
    end else begin
      error_flag_d = error_flag_q;
    end

    seen_next = seen_mask_q | commit_mask;
    if (&seen_next) begin
      frame_done_d = 1'b1;
      seen_mask_d  = '0;
    end else begin
      frame_done_d = 1'b0;
      seen_mask_d  = seen_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_seg_q     <= SEG_BLANK;
      last_anode_q   <= '1;
      stable_count_q <= 8'd0;
      state_q        <= ST_IDLE;
      digit_bits_q   <= '0;
      digit_valid_q  <= '0;
      seen_mask_q    <= '0;
      error_flag_q   <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      last_seg_q     <= last_seg_d;
      last_anode_q   <= last_anode_d;
      stable_count_q <= stable_count_d;
      state_q        <= state_d;
      digit_bits_q   <= digit_bits_d;
      digit_valid_q  <= digit_valid_d;
      seen_mask_q    <= seen_mask_d;
      error_flag_q   <= error_flag_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign digitBits  = digit_bits_q;
  assign digitValid = digit_valid_q;
  assign errorFlag  = error_flag_q;
  assign frameDone  = frame_done_q;

endmodule

// File: tb/tb_segment_display_capture.sv
// Directed bench for segment_display_capture with NUM_DIGITS=4, STABLE_CYCLES=4;
// expected values are hand-computed per step.
module tb_segment_display_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segBits;
  logic [3:0]  anodeBits;
  logic        clearError;
  logic [15:0] digitBits;
  logic [3:0]  digitValid;
  logic        errorFlag;
  logic        frameDone;

  int vectors     = 0;
  int miscompares = 0;

  segment_display_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .segBits    (segBits),
    .anodeBits  (anodeBits),
    .clearError (clearError),
    .digitBits  (digitBits),
    .digitValid (digitValid),
    .errorFlag  (errorFlag),
    .frameDone  (frameDone)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    segBits    = 7'h7F;
    anodeBits  = 4'b1111;
    clearError = 1'b0;
    tick(2);
    reset = 1'b0;

    chk("reset_bits",  digitBits,  16'h0000);
    chk("reset_valid", digitValid, 16'h0);
    chk("reset_err",   errorFlag,  16'h0);
    chk("reset_frame", frameDone,  16'h0);

    // Single digit: '2' on digit 0, commit on the fourth edge after E0.
    anodeBits = 4'b1110; segBits = 7'b0100100;
    tick(4);
    chk("single_early_valid", digitValid, 16'h0);
    tick(1);
    chk("single_bits",  digitBits,  16'h0002);
    chk("single_valid", digitValid, 16'h1);
    tick(3);
    chk("single_hold_valid", digitValid, 16'h1);
    chk("single_hold_frame", frameDone,  16'h0);

    // Glitch on digit 1: '2' for two edges, then 'A' held.
    anodeBits = 4'b1101; segBits = 7'b0100100;
    tick(2);
    segBits = 7'b0001000;
    tick(4);
    chk("glitch_early_bits",  digitBits,  16'h0002);
    chk("glitch_early_valid", digitValid, 16'h1);
    tick(1);
    chk("glitch_bits",  digitBits,  16'h00A2);
    chk("glitch_valid", digitValid, 16'h3);

    // Full frame from a clean reset: 1, 3, b, C.
    anodeBits = 4'b1111; segBits = 7'h7F;
    do_reset();
    chk("frame_reset_bits", digitBits, 16'h0000);
    anodeBits = 4'b1110; segBits = 7'b1111001; tick(5);
    anodeBits = 4'b1101; segBits = 7'b0110000; tick(5);
    anodeBits = 4'b1011; segBits = 7'b0000011; tick(5);
    chk("frame_partial_done", frameDone, 16'h0);
    anodeBits = 4'b0111; segBits = 7'b1000110; tick(5);
    chk("frame_bits",  digitBits,  16'hCB31);
    chk("frame_valid", digitValid, 16'hF);
    chk("frame_done",  frameDone,  16'h1);
    tick(1);
    chk("frame_done_drop", frameDone, 16'h0);

    // Blank on digit 2: invalidates without error, keeps the nibble.
    anodeBits = 4'b1011; segBits = 7'b1111111; tick(5);
    chk("blank_valid", digitValid, 16'hB);
    chk("blank_err",   errorFlag,  16'h0);
    chk("blank_bits",  digitBits,  16'hCB31);

    // Illegal pattern on digit 3.
    anodeBits = 4'b0111; segBits = 7'b0101010; tick(4);
    chk("illegal_early_err", errorFlag, 16'h0);
    tick(1);
    chk("illegal_err",   errorFlag,  16'h1);
    chk("illegal_valid", digitValid, 16'h3);
    chk("illegal_bits",  digitBits,  16'hCB31);
    tick(3);
    chk("illegal_sticky", errorFlag, 16'h1);

    // clearError together with a fresh multi-anode error: error wins.
    anodeBits = 4'b0011; clearError = 1'b1; tick(1);
    chk("multi_clear_race", errorFlag, 16'h1);
    tick(1);
    chk("multi_clear_ok", errorFlag, 16'h0);
    clearError = 1'b0;
    tick(3);
    chk("multi_held_err",   errorFlag,  16'h0);
    chk("multi_no_commit",  digitValid, 16'h3);
    chk("multi_bits",       digitBits,  16'hCB31);
    chk("multi_frame",      frameDone,  16'h0);

    // Reset two edges into a dwell, pattern '6' held throughout.
    anodeBits = 4'b1110; segBits = 7'b0000010;
    tick(2);
    do_reset();
    chk("midreset_bits",  digitBits,  16'h0000);
    chk("midreset_valid", digitValid, 16'h0);
    chk("midreset_err",   errorFlag,  16'h0);
    chk("midreset_frame", frameDone,  16'h0);
    tick(3);
    chk("midreset_early_valid", digitValid, 16'h0);
    tick(2);
    chk("midreset_valid_after", digitValid, 16'h1);
    chk("midreset_bits_after",  digitBits,  16'h0006);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
